// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC into a synchronous instruction ROM and hands each word to ID.
// A single held word bridges hazard stalls; a taken branch squashes and refills from the target.
module instruction_fetch #(
  parameter int                 ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter logic [5:0]         NOP_OP   = 6'h00
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [ADDR_W-1:0] oInstrAddr,
  input  logic [15:0]       iInstruction,
  output logic [5:0]        oOperation_IF,
  output logic [9:0]        oData_IF,
  output logic              oValid_IF,
  output logic [ADDR_W-1:0] oPC_IF
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            rState;
  logic [ADDR_W-1:0] rPC;
  logic [ADDR_W-1:0] rFetchPC;
  logic [15:0]       rHold;
  logic [ADDR_W-1:0] rHoldPC;
  logic [ADDR_W-1:0] w_pc_inc;

  // Natural truncation gives the 2**ADDR_W wrap.
  assign w_pc_inc   = rPC + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign oInstrAddr = rPC;

  // Output select: ROM data in RUN, held word on HOLD release, bubble otherwise.
  always_comb begin
    oOperation_IF = NOP_OP;
    oData_IF      = 10'd0;
    oValid_IF     = 1'b0;
    oPC_IF        = {ADDR_W{1'b0}};
    if (Reset || iBranchTaken || iStall) begin
      oValid_IF = 1'b0;
    end else begin
      case (rState)
        S_RUN: begin
          oOperation_IF = iInstruction[15:10];
          oData_IF      = iInstruction[9:0];
          oValid_IF     = 1'b1;
          oPC_IF        = rFetchPC;
        end
        S_HOLD: begin
          oOperation_IF = rHold[15:10];
          oData_IF      = rHold[9:0];
          oValid_IF     = 1'b1;
          oPC_IF        = rHoldPC;
        end
        default: oValid_IF = 1'b0;
      endcase
    end
  end

  // Fetch FSM and PC bookkeeping; priority Reset > branch > stall.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rPC      <= RESET_PC;
      rFetchPC <= {ADDR_W{1'b0}};
      rHold    <= 16'd0;
      rHoldPC  <= {ADDR_W{1'b0}};
      rState   <= S_FILL;
    end else if (iBranchTaken) begin
      rPC    <= iBranchTarget;
      rHold  <= 16'd0;
      rState <= S_FILL;
    end else begin
      case (rState)
        S_FILL: begin
          rFetchPC <= rPC;
          rPC      <= w_pc_inc;
          rState   <= S_RUN;
        end
        S_RUN: begin
          if (iStall) begin
            // rPC stays put so the ROM re-presents the next word when the stall ends.
            rHold   <= iInstruction;
            rHoldPC <= rFetchPC;
            rState  <= S_HOLD;
          end else begin
            rFetchPC <= rPC;
            rPC      <= w_pc_inc;
            rState   <= S_RUN;
          end
        end
        S_HOLD: begin
          if (iStall) begin
            rState <= S_HOLD;
          end else begin
            rFetchPC <= rPC;
            rPC      <= w_pc_inc;
            rState   <= S_RUN;
          end
        end
        default: rState <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a stream-level model (next word to deliver plus a
// warm-up flag) is compared every cycle, with literal spot checks pinning the model.
module tb_instruction_fetch;

  localparam int ADDR_W = 10;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              iStall = 1'b0;
  logic              iBranchTaken = 1'b0;
  logic [ADDR_W-1:0] iBranchTarget = 10'd0;
  logic [ADDR_W-1:0] oInstrAddr;
  logic [15:0]       iInstruction = 16'd0;
  logic [5:0]        oOperation_IF;
  logic [9:0]        oData_IF;
  logic              oValid_IF;
  logic [ADDR_W-1:0] oPC_IF;

  int vectors = 0;
  int miscompares = 0;

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(10'd0), .NOP_OP(6'h00)) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .oInstrAddr(oInstrAddr), .iInstruction(iInstruction),
    .oOperation_IF(oOperation_IF), .oData_IF(oData_IF), .oValid_IF(oValid_IF), .oPC_IF(oPC_IF)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM with ROM[i] = {6'(i), 10'(i)}
  always @(posedge Clock) iInstruction <= {oInstrAddr[5:0], oInstrAddr};

  // Stream model: after a (re)start at address A, one fill cycle, then A, A+1, ... one per unstalled cycle.
  logic              m_on = 1'b0;
  logic              m_warm = 1'b0;
  logic [ADDR_W-1:0] m_nxt = 10'd0;
  logic              e_valid;
  logic [5:0]        e_op;
  logic [9:0]        e_data;
  logic [ADDR_W-1:0] e_pc;
  logic [ADDR_W-1:0] e_addr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    vectors++;
    e_valid = 1'b0; e_op = 6'h00; e_data = 10'd0; e_pc = 10'd0;
    if (!Reset && !iBranchTaken && m_warm && !iStall) begin
      e_valid = 1'b1; e_op = m_nxt[5:0]; e_data = m_nxt; e_pc = m_nxt;
    end
    e_addr = m_warm ? 10'(m_nxt + 10'd1) : m_nxt;
    chk("valid", {15'd0, oValid_IF}, {15'd0, e_valid});
    chk("operation", {10'd0, oOperation_IF}, {10'd0, e_op});
    chk("data", {6'd0, oData_IF}, {6'd0, e_data});
    chk("pc_if", {6'd0, oPC_IF}, {6'd0, e_pc});
    if (m_on) chk("instr_addr", {6'd0, oInstrAddr}, {6'd0, e_addr});
    if (Reset) begin
      m_on = 1'b1; m_nxt = 10'd0; m_warm = 1'b0;
    end else if (iBranchTaken) begin
      m_nxt = iBranchTarget; m_warm = 1'b0;
    end else if (!m_warm) begin
      m_warm = 1'b1;
    end else if (!iStall) begin
      m_nxt = 10'(m_nxt + 10'd1);
    end
  end

  // Drive one cycle's inputs just after the edge; return after the negedge compare.
  task automatic step(input logic rst, input logic br, input logic [9:0] tgt, input logic st);
    @(posedge Clock); #1;
    Reset = rst; iBranchTaken = br; iBranchTarget = tgt; iStall = st;
    @(negedge Clock); #1;
  endtask

  task automatic pin(input string name, input logic v, input logic [9:0] pc);
    chk({name, "_valid"}, {15'd0, oValid_IF}, {15'd0, v});
    if (v) begin
      chk({name, "_pc"}, {6'd0, oPC_IF}, {6'd0, pc});
      chk({name, "_data"}, {6'd0, oData_IF}, {6'd0, pc});
      chk({name, "_op"}, {10'd0, oOperation_IF}, {10'd0, pc[5:0]});
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("fill", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("word0", 1'b1, 10'd0);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b0, 10'd0, 1'b0); pin("stream", 1'b1, 10'(i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 10'd0, 1'b1); pin("stall", 1'b0, 10'd0);
    end
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("resume5", 1'b1, 10'd5);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("resume6", 1'b1, 10'd6);
    step(1'b0, 1'b1, 10'h200, 1'b0); pin("squash7", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("br_fill", 1'b0, 10'd0);
    chk("br_addr", {6'd0, oInstrAddr}, 16'h0200);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("target", 1'b1, 10'h200);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("target1", 1'b1, 10'h201);
    // Branch and stall together: branch wins, stall during the fill is ignored.
    step(1'b0, 1'b1, 10'h3FD, 1'b1); pin("br_stall", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b1);  pin("fill_stall", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("w3fd", 1'b1, 10'h3FD);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("w3fe", 1'b1, 10'h3FE);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("w3ff", 1'b1, 10'h3FF);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("wrap0", 1'b1, 10'h000);
    // Back-to-back and single-cycle stalls.
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("b2b_a", 1'b1, 10'h001);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("b2b_b", 1'b1, 10'h002);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("b2b_c", 1'b1, 10'h003);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("b2b_d", 1'b1, 10'h004);
    // Reset during HOLD: held word 5 must never appear.
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b1, 1'b0, 10'd0, 1'b1);  pin("rst_hold", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("rst_fill", 1'b0, 10'd0);
    chk("rst_addr", {6'd0, oInstrAddr}, 16'h0000);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("rst_w0", 1'b1, 10'h000);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("rst_w1", 1'b1, 10'h001);
    // Branch during HOLD drops the held word.
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    step(1'b0, 1'b1, 10'h100, 1'b1); pin("br_hold", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("brh_fill", 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0);  pin("brh_w", 1'b1, 10'h100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 10'd0, (i % 3) == 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
